// File: rtl/cpu_pkg.sv
// Shared definitions for the parametrised core: opcodes, FSM states and
// instruction-field bit positions.
package cpu_pkg;

   localparam logic [7:0] OP_LOADI = 8'h00;
   localparam logic [7:0] OP_MOV   = 8'h01;
   localparam logic [7:0] OP_ADD   = 8'h02;
   localparam logic [7:0] OP_SUB   = 8'h03;
   localparam logic [7:0] OP_AND   = 8'h04;
   localparam logic [7:0] OP_OR    = 8'h05;
   localparam logic [7:0] OP_J     = 8'h06;
   localparam logic [7:0] OP_BEQ   = 8'h07;
   localparam logic [7:0] OP_HALT  = 8'h08;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_e;

   localparam int OPC_LSB = 24;
   localparam int OFF_LSB = 16;
   localparam int RD_LSB  = 16;
   localparam int RS1_LSB = 8;
   localparam int RS2_LSB = 0;
   localparam int IMM_LSB = 0;

endpackage

// File: rtl/reg_file_p.sv
// Register file: two combinational read ports, one synchronous write port,
// asynchronous active-low clear of every entry.
module reg_file_p #(
   parameter int DATA_W = 8,
   parameter int NREG   = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     we_i,
   input  logic [$clog2(NREG)-1:0]  waddr_i,
   input  logic [DATA_W-1:0]        wdata_i,
   input  logic [$clog2(NREG)-1:0]  raddr1_i,
   input  logic [$clog2(NREG)-1:0]  raddr2_i,
   output logic [DATA_W-1:0]        rdata1_o,
   output logic [DATA_W-1:0]        rdata2_o
);

   logic [DATA_W-1:0] regs_q [NREG];

   // NOTE: the clear is part of the architectural reset, so the array is reset
   // like any other flop; that keeps it a flop array rather than a RAM macro.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      end else if (we_i) begin
         // NOTE: non-blocking so a same-edge read sees the pre-edge value.
         regs_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata1_o = regs_q[raddr1_i];
   assign rdata2_o = regs_q[raddr2_i];

endmodule

// File: rtl/cpu_core_p.sv
// Single-issue core: one instruction per accepted fetch, inline ALU,
// next-PC logic and RUN/HALT FSM around the reg_file_p register file.
module cpu_core_p
   import cpu_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int NREG   = 8,
   parameter int PC_W   = 32
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic [31:0]     INSTRUCTION,
   input  logic            INSTR_VALID,
   output logic [PC_W-1:0] PC,
   output logic            HALTED,
   output logic            ILLEGAL,
   output logic            ZERO
);

   localparam int AW = $clog2(NREG);

   state_e            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic              zero_q, zero_d;
   logic              ill_q, ill_d;

   logic [7:0]        opcode;
   logic signed [7:0] off_s;
   logic signed [7:0] imm_s;
   logic [AW-1:0]     rd, rs1, rs2;
   logic [DATA_W-1:0] rs1_val, rs2_val, alu_res;
   logic              wr_en, accept;
   logic [PC_W-1:0]   pc_seq, pc_br;
   logic              instr_unused;

   assign opcode = INSTRUCTION[OPC_LSB +: 8];
   assign off_s  = INSTRUCTION[OFF_LSB +: 8];
   assign imm_s  = INSTRUCTION[IMM_LSB +: 8];
   assign rd     = INSTRUCTION[RD_LSB  +: AW];
   assign rs1    = INSTRUCTION[RS1_LSB +: AW];
   assign rs2    = INSTRUCTION[RS2_LSB +: AW];
   assign instr_unused = ^INSTRUCTION;

   assign accept = (state_q == ST_RUN) && INSTR_VALID;
   assign pc_seq = pc_q + PC_W'(4);
   // Signed cast widens the word offset before scaling to bytes.
   assign pc_br  = pc_seq + (PC_W'(off_s) << 2);

   reg_file_p #(.DATA_W(DATA_W), .NREG(NREG)) u_rf (
      .clk      (CLK),
      .rst_n    (RESET),
      .we_i     (wr_en),
      .waddr_i  (rd),
      .wdata_i  (alu_res),
      .raddr1_i (rs1),
      .raddr2_i (rs2),
      .rdata1_o (rs1_val),
      .rdata2_o (rs2_val)
   );

   // NOTE: every output of this block gets a default first, so no path infers a latch.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      zero_d  = zero_q;
      ill_d   = 1'b0;
      wr_en   = 1'b0;
      alu_res = '0;
      if (accept) begin
         pc_d = pc_seq;
         case (opcode)
            OP_LOADI: begin alu_res = DATA_W'(imm_s);      wr_en = 1'b1; end
            OP_MOV:   begin alu_res = rs2_val;             wr_en = 1'b1; end
            OP_ADD:   begin alu_res = rs1_val + rs2_val;   wr_en = 1'b1; end
            OP_SUB:   begin alu_res = rs1_val - rs2_val;   wr_en = 1'b1; end
            OP_AND:   begin alu_res = rs1_val & rs2_val;   wr_en = 1'b1; end
            OP_OR:    begin alu_res = rs1_val | rs2_val;   wr_en = 1'b1; end
            OP_J:     pc_d = pc_br;
            OP_BEQ:   if (rs1_val == rs2_val) pc_d = pc_br;
            OP_HALT:  begin state_d = ST_HALT; pc_d = pc_q; end
            default:  ill_d = 1'b1;
         endcase
         if (wr_en) zero_d = (alu_res == '0);
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q <= ST_RUN;
         pc_q    <= '0;
         zero_q  <= 1'b0;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         zero_q  <= zero_d;
         ill_q   <= ill_d;
      end
   end

   assign PC      = pc_q;
   assign HALTED  = (state_q == ST_HALT);
   assign ILLEGAL = ill_q;
   assign ZERO    = zero_q;

endmodule

// File: tb/tb_cpu_core_p.sv
// Bench for cpu_core_p: an instruction-level model tracks the 8-bit core every
// cycle; a second 16-bit, 4-register instance gets a few directed checks.
module tb_cpu_core_p;
   import cpu_pkg::*;

   logic        CLK;
   logic        RESET;
   logic [31:0] instr_a, instr_b;
   logic        valid_a, valid_b;
   logic [31:0] pc_a, pc_b;
   logic        halted_a, halted_b, ill_a, ill_b, zero_a, zero_b;

   int n_vec = 0;
   int n_err = 0;

   cpu_core_p #(.DATA_W(8), .NREG(8), .PC_W(32)) dut_a (
      .CLK(CLK), .RESET(RESET), .INSTRUCTION(instr_a), .INSTR_VALID(valid_a),
      .PC(pc_a), .HALTED(halted_a), .ILLEGAL(ill_a), .ZERO(zero_a));

   cpu_core_p #(.DATA_W(16), .NREG(4), .PC_W(32)) dut_b (
      .CLK(CLK), .RESET(RESET), .INSTRUCTION(instr_b), .INSTR_VALID(valid_b),
      .PC(pc_b), .HALTED(halted_b), .ILLEGAL(ill_b), .ZERO(zero_b));

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] op_i(input logic [7:0] op, input logic [2:0] rd, input logic [7:0] imm);
      return {op, 5'b0, rd, 8'b0, imm};
   endfunction

   function automatic logic [31:0] op_r(input logic [7:0] op, input logic [2:0] rd,
                                       input logic [2:0] s1, input logic [2:0] s2);
      return {op, 5'b0, rd, 5'b0, s1, 5'b0, s2};
   endfunction

   function automatic logic [31:0] op_b(input logic [7:0] op, input logic [7:0] off,
                                       input logic [2:0] s1, input logic [2:0] s2);
      return {op, off, 5'b0, s1, 5'b0, s2};
   endfunction

   // Instruction-level reference model of the 8-bit, 8-register core.
   logic [7:0]  m_reg [8];
   logic [31:0] m_pc   = '0;
   logic        m_halt = 1'b0;
   logic        m_ill  = 1'b0;
   logic        m_zero = 1'b0;

   initial for (int i = 0; i < 8; i++) m_reg[i] = '0;

   always @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         m_pc   <= '0;
         m_halt <= 1'b0;
         m_ill  <= 1'b0;
         m_zero <= 1'b0;
         for (int i = 0; i < 8; i++) m_reg[i] <= '0;
      end else begin
         automatic int          op  = int'(instr_a[31:24]);
         automatic int          a   = int'(m_reg[instr_a[10:8]]);
         automatic int          b   = int'(m_reg[instr_a[2:0]]);
         automatic int          off = int'($signed(instr_a[23:16]));
         automatic int          res = 0;
         automatic logic [7:0]  r8;
         m_ill <= 1'b0;
         if (!m_halt && valid_a) begin
            case (op)
               0: res = int'($signed(instr_a[7:0]));
               1: res = b;
               2: res = a + b;
               3: res = a - b;
               4: res = a & b;
               5: res = a | b;
               default: res = 0;
            endcase
            r8 = res[7:0];
            if (op <= 5) begin
               m_reg[instr_a[18:16]] <= r8;
               m_zero <= (r8 == 8'h00);
            end
            if (op == 8)                 m_halt <= 1'b1;
            else if (op == 6)            m_pc <= m_pc + 32'(4 + off * 4);
            else if (op == 7 && a == b)  m_pc <= m_pc + 32'(4 + off * 4);
            else                         m_pc <= m_pc + 32'd4;
            if (op > 8) m_ill <= 1'b1;
         end
      end
   end

   always @(negedge CLK) begin
      check("pc", pc_a, m_pc);
      check("halted", halted_a, m_halt);
      check("illegal", ill_a, m_ill);
      check("zero", zero_a, m_zero);
      for (int i = 0; i < 8; i++)
         check($sformatf("r%0d", i), dut_a.u_rf.regs_q[i], m_reg[i]);
   end

   task automatic exec_a(input logic [31:0] ins);
      instr_a = ins;
      valid_a = 1'b1;
      @(posedge CLK);
      #1;
      valid_a = 1'b0;
   endtask

   task automatic exec_b(input logic [31:0] ins);
      instr_b = ins;
      valid_b = 1'b1;
      @(posedge CLK);
      #1;
      valid_b = 1'b0;
   endtask

   initial begin
      RESET   = 1'b1;
      instr_a = '0;
      instr_b = '0;
      valid_a = 1'b0;
      valid_b = 1'b0;
      #2 RESET = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      check("rst_pc", pc_a, 32'h0);
      check("rst_halted", halted_a, 1'b0);
      check("rst_illegal", ill_a, 1'b0);
      check("rst_zero", zero_a, 1'b0);
      RESET = 1'b1;

      exec_a(32'hFF00_0000);
      check("nop_pc4", pc_a, 32'h4);
      check("ill_first", ill_a, 1'b1);
      exec_a(32'hFF00_0000);
      check("nop_pc8", pc_a, 32'h8);
      check("ill_b2b", ill_a, 1'b1);

      exec_a(op_i(OP_LOADI, 3'd1, 8'h7F));
      check("ill_clear", ill_a, 1'b0);
      exec_a(op_i(OP_LOADI, 3'd2, 8'h01));
      exec_a(op_r(OP_ADD, 3'd3, 3'd1, 3'd2));
      check("add_r3", dut_a.u_rf.regs_q[3], 8'h80);
      check("add_zero", zero_a, 1'b0);
      exec_a(op_r(OP_SUB, 3'd4, 3'd3, 3'd3));
      check("sub_r4", dut_a.u_rf.regs_q[4], 8'h00);
      check("sub_zero", zero_a, 1'b1);
      check("sub_pc", pc_a, 32'h18);

      exec_a(op_i(OP_LOADI, 3'd1, 8'h05));
      exec_a(op_i(OP_LOADI, 3'd2, 8'h05));
      exec_a(op_b(OP_J, 8'hFB, 3'd0, 3'd0));
      check("j_back", pc_a, 32'h10);
      exec_a(op_b(OP_BEQ, 8'hFE, 3'd1, 3'd2));
      check("beq_taken", pc_a, 32'h0C);
      exec_a(op_i(OP_LOADI, 3'd2, 8'h06));
      exec_a(op_b(OP_BEQ, 8'hFE, 3'd1, 3'd2));
      check("beq_not_taken", pc_a, 32'h14);
      exec_a(op_b(OP_J, 8'hFE, 3'd0, 3'd0));
      exec_a(op_b(OP_J, 8'h7F, 3'd0, 3'd0));
      check("j_far", pc_a, 32'h210);

      for (int i = 0; i < 3; i++) begin
         instr_a = $urandom;
         valid_a = 1'b0;
         @(posedge CLK);
         #1;
         check("stall_pc", pc_a, 32'h210);
         check("stall_r5", dut_a.u_rf.regs_q[5], 8'h00);
      end
      exec_a(op_i(OP_LOADI, 3'd5, 8'h33));
      check("stall_exec_r5", dut_a.u_rf.regs_q[5], 8'h33);
      check("stall_exec_pc", pc_a, 32'h214);

      exec_a(op_r(OP_AND, 3'd6, 3'd5, 3'd1));
      check("and_r6", dut_a.u_rf.regs_q[6], 8'h01);
      exec_a(op_r(OP_OR, 3'd7, 3'd5, 3'd2));
      check("or_r7", dut_a.u_rf.regs_q[7], 8'h37);
      exec_a(op_r(OP_MOV, 3'd0, 3'd0, 3'd7));
      check("mov_r0", dut_a.u_rf.regs_q[0], 8'h37);
      exec_a(op_b(OP_J, 8'h80, 3'd0, 3'd0));
      check("j_min", pc_a, 32'h24);
      exec_a(op_b(OP_J, 8'hFE, 3'd0, 3'd0));
      check("pre_halt_pc", pc_a, 32'h20);

      exec_a(op_b(OP_HALT, 8'h00, 3'd0, 3'd0));
      check("halt_flag", halted_a, 1'b1);
      for (int i = 0; i < 10; i++) begin
         instr_a = op_i(OP_LOADI, 3'd1, 8'h99);
         valid_a = i[0];
         @(posedge CLK);
         #1;
         check("halt_pc", pc_a, 32'h20);
      end
      check("halt_r1", dut_a.u_rf.regs_q[1], 8'h05);
      valid_a = 1'b0;

      @(posedge CLK);
      #1 RESET = 1'b0;
      #1;
      check("async_pc", pc_a, 32'h0);
      check("async_halted", halted_a, 1'b0);
      check("async_r7", dut_a.u_rf.regs_q[7], 8'h00);
      #1 RESET = 1'b1;
      exec_a(op_i(OP_LOADI, 3'd1, 8'h00));
      check("post_rst_pc", pc_a, 32'h4);
      check("post_rst_zero", zero_a, 1'b1);

      exec_b(op_i(OP_LOADI, 3'd0, 8'hF0));
      check("b_sext", dut_b.u_rf.regs_q[0], 16'hFFF0);
      check("b_zero", zero_b, 1'b0);
      exec_b(op_i(OP_LOADI, 3'b110, 8'h05));
      check("b_rd_wrap", dut_b.u_rf.regs_q[2], 16'h0005);
      exec_b(op_r(OP_MOV, 3'd1, 3'd0, 3'b010));
      check("b_mov", dut_b.u_rf.regs_q[1], 16'h0005);
      check("b_pc", pc_b, 32'hC);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
